// File: rtl/nav_pkg.sv
// Shared encodings for the dungeon navigation engine:
// tile codes, command codes, event codes, FSM states and a radius helper.
package nav_pkg;

    typedef enum logic [3:0] {
        TILE_UNKNOWN  = 4'd0,
        TILE_CURRENT  = 4'd1,
        TILE_ENTRANCE = 4'd2,
        TILE_EXIT     = 4'd3,
        TILE_BLANK    = 4'd4,
        TILE_WALL     = 4'd5
    } nav_tile_e;

    localparam logic [7:0] CMD_RIGHT     = 8'h01;
    localparam logic [7:0] CMD_LEFT      = 8'h02;
    localparam logic [7:0] CMD_UP        = 8'h03;
    localparam logic [7:0] CMD_DOWN      = 8'h04;
    localparam logic [7:0] CMD_NO_SHROUD = 8'h10;
    localparam logic [7:0] CMD_NO_CLIP   = 8'h11;

    typedef enum logic [2:0] {
        EVT_MOVED   = 3'd0,
        EVT_BLOCKED = 3'd1,
        EVT_EXIT    = 3'd2,
        EVT_TOGGLED = 3'd3,
        EVT_ILLEGAL = 3'd4
    } nav_evt_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_REVEAL = 2'd2,
        ST_DONE   = 2'd3
    } nav_state_e;

    // Manhattan length of a signed 4-bit offset pair (offsets stay within -7..7).
    function automatic logic [4:0] manhattan(input logic signed [3:0] dx,
                                             input logic signed [3:0] dy);
        logic [3:0] ax;
        logic [3:0] ay;
        ax = dx[3] ? 4'(-dx) : 4'(dx);
        ay = dy[3] ? 4'(-dy) : 4'(dy);
        return {1'b0, ax} + {1'b0, ay};
    endfunction

endpackage

// File: rtl/nav_reveal_sweep.sv
// Fog-of-war reveal sweep: walks a (2R+1)^2 window around the player, one cell
// per cycle, and emits a seen-bit write for in-bounds cells within radius R.
module nav_reveal_sweep
    import nav_pkg::*;
#(
    parameter int MAP_W  = 20,
    parameter int MAP_H  = 20,
    parameter int VIEW_R = 2,
    parameter int AW     = 9,
    parameter int XW     = 5,
    parameter int YW     = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [XW-1:0] cx_i,
    input  logic [YW-1:0] cy_i,
    output logic          cell_we_o,
    output logic [AW-1:0] cell_addr_o,
    output logic          last_o
);

    // Headroom bits so a negative or overshooting offset can never alias onto a legal cell.
    localparam int CXW = XW + 4;
    localparam int CYW = YW + 4;
    localparam logic signed [3:0] R_POS   = 4'(VIEW_R);
    localparam logic signed [3:0] R_NEG   = -R_POS;
    localparam logic [CXW-1:0]    MAP_W_C = CXW'(MAP_W);
    localparam logic [CYW-1:0]    MAP_H_C = CYW'(MAP_H);

    logic signed [3:0] dx_q, dx_d, dy_q, dy_d;
    logic              active_q, active_d;
    logic [CXW-1:0]    cell_x_s;
    logic [CYW-1:0]    cell_y_s;
    logic              in_bounds_s;

    // Sweep counters; reset re-arms the sweep so the start window is revealed.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b1;
            dx_q     <= R_NEG;
            dy_q     <= R_NEG;
        end else begin
            active_q <= active_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
        end
    end

    // Raster order: dx is the inner loop, dy the outer loop.
    always_comb begin
        active_d = active_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        if (start_i) begin
            active_d = 1'b1;
            dx_d     = R_NEG;
            dy_d     = R_NEG;
        end else if (active_q) begin
            if (dx_q == R_POS) begin
                dx_d = R_NEG;
                if (dy_q == R_POS) begin
                    active_d = 1'b0;
                end else begin
                    dy_d = dy_q + 4'sd1;
                end
            end else begin
                dx_d = dx_q + 4'sd1;
            end
        end else begin
            active_d = 1'b0;
        end
    end

    // Cell qualification and address generation for the current offset.
    always_comb begin
        cell_x_s    = CXW'(cx_i) + CXW'(dx_q);
        cell_y_s    = CYW'(cy_i) + CYW'(dy_q);
        in_bounds_s = !cell_x_s[CXW-1] && (cell_x_s < MAP_W_C) &&
                      !cell_y_s[CYW-1] && (cell_y_s < MAP_H_C);
        cell_addr_o = AW'(cell_y_s) * AW'(MAP_W) + AW'(cell_x_s);
        cell_we_o   = active_q && in_bounds_s &&
                      (manhattan(dx_q, dy_q) <= {1'b0, R_POS});
        last_o      = active_q && (dx_q == R_POS) && (dy_q == R_POS);
    end

endmodule

// File: rtl/dungeon_nav_engine.sv
// Player-navigation core: tile map, position, fog-of-war and command FSM.
// Cheat commands (no_shroud / no_clip) are compiled in with `define NAV_CHEATS_EN.
module dungeon_nav_engine
    import nav_pkg::*;
#(
    parameter int MAP_W   = 20,
    parameter int MAP_H   = 20,
    parameter int TILE_W  = 4,
    parameter int VIEW_R  = 2,
    parameter int START_X = 10,
    parameter int START_Y = 2,
    localparam int N  = MAP_W * MAP_H,
    localparam int AW = $clog2(N),
    localparam int XW = $clog2(MAP_W),
    localparam int YW = $clog2(MAP_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              map_we,
    input  logic [AW-1:0]     map_waddr,
    input  logic [TILE_W-1:0] map_wdata,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd,
    output logic              cmd_ready,
    output logic              busy,
    output logic              evt_valid,
    output logic [2:0]        evt_code,
    output logic [XW-1:0]     pos_x,
    output logic [YW-1:0]     pos_y,
    input  logic [AW-1:0]     rd_addr,
    output logic [TILE_W-1:0] rd_tile,
    output logic              rd_seen,
    output logic              no_shroud
);

    localparam logic [XW:0]       MAP_W_X   = (XW+1)'(MAP_W);
    localparam logic [YW:0]       MAP_H_Y   = (YW+1)'(MAP_H);
    localparam logic [XW:0]       ONE_X     = (XW+1)'(1);
    localparam logic [YW:0]       ONE_Y     = (YW+1)'(1);
    localparam logic [AW:0]       N_A       = (AW+1)'(N);
    localparam logic [XW-1:0]     START_X_P = XW'(START_X);
    localparam logic [YW-1:0]     START_Y_P = YW'(START_Y);
    localparam logic [TILE_W-1:0] T_WALL    = TILE_W'(TILE_WALL);
    localparam logic [TILE_W-1:0] T_EXIT    = TILE_W'(TILE_EXIT);

    logic [TILE_W-1:0] map_mem [N];
    logic [N-1:0]      seen_q;
    nav_state_e        state_q, state_d;
    nav_evt_e          code_q, code_d;
    logic [7:0]        cmd_q;
    logic [XW-1:0]     pos_x_q, pos_x_d;
    logic [YW-1:0]     pos_y_q, pos_y_d;
    logic              cmd_ready_q, evt_valid_q, evt_valid_d, boot_q;
    logic [TILE_W-1:0] rd_tile_q;
    logic              rd_seen_q;
    logic              no_shroud_s, no_clip_s, is_cheat_s;
    logic [XW:0]       tx_s;
    logic [YW:0]       ty_s;
    logic              is_move_s, oob_s, blocked_s, sweep_start_s;
    logic [AW-1:0]     tgt_addr_s;
    logic [TILE_W-1:0] tgt_tile_s;
    logic              cell_we_s, sweep_last_s;
    logic [AW-1:0]     cell_addr_s;

    // Map RAM is never reset and accepts writes in every FSM state.
    always_ff @(posedge clk) begin
        if (map_we && ({1'b0, map_waddr} < N_A)) begin
            map_mem[map_waddr] <= map_wdata;
        end
    end

    // Render read port, one cycle of latency, independent of the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_tile_q <= {TILE_W{1'b0}};
            rd_seen_q <= 1'b0;
        end else if ({1'b0, rd_addr} < N_A) begin
            rd_tile_q <= map_mem[rd_addr];
            rd_seen_q <= no_shroud_s | seen_q[rd_addr];
        end else begin
            rd_tile_q <= {TILE_W{1'b0}};
            rd_seen_q <= no_shroud_s;
        end
    end

    // Seen bitmap: cleared by reset, set by the reveal sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_q <= {N{1'b0}};
        end else if (cell_we_s) begin
            seen_q[cell_addr_s] <= 1'b1;
        end
    end

`ifdef NAV_CHEATS_EN
    logic no_shroud_q, no_clip_q;

    // Cheat flags toggle during EXEC of their command.
    always_ff @(posedge clk) begin
        if (reset) begin
            no_shroud_q <= 1'b0;
            no_clip_q   <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            if (cmd_q == CMD_NO_SHROUD) no_shroud_q <= ~no_shroud_q;
            if (cmd_q == CMD_NO_CLIP)   no_clip_q   <= ~no_clip_q;
        end
    end

    assign no_shroud_s = no_shroud_q;
    assign no_clip_s   = no_clip_q;
    assign is_cheat_s  = (cmd_q == CMD_NO_SHROUD) || (cmd_q == CMD_NO_CLIP);
`else
    assign no_shroud_s = 1'b0;
    assign no_clip_s   = 1'b0;
    assign is_cheat_s  = 1'b0;
`endif

    // Move target, bounds and wall check; the RAM read sees the pre-write value.
    always_comb begin
        tx_s      = {1'b0, pos_x_q};
        ty_s      = {1'b0, pos_y_q};
        oob_s     = 1'b0;
        is_move_s = 1'b1;
        case (cmd_q)
            CMD_RIGHT: begin
                tx_s  = tx_s + ONE_X;
                oob_s = (tx_s >= MAP_W_X);
            end
            CMD_LEFT: begin
                oob_s = (pos_x_q == {XW{1'b0}});
                tx_s  = tx_s - ONE_X;
            end
            CMD_UP: begin
                oob_s = (pos_y_q == {YW{1'b0}});
                ty_s  = ty_s - ONE_Y;
            end
            CMD_DOWN: begin
                ty_s  = ty_s + ONE_Y;
                oob_s = (ty_s >= MAP_H_Y);
            end
            default: is_move_s = 1'b0;
        endcase
        tgt_addr_s = AW'(ty_s) * AW'(MAP_W) + AW'(tx_s);
        if ({1'b0, tgt_addr_s} < N_A) begin
            tgt_tile_s = map_mem[tgt_addr_s];
        end else begin
            tgt_tile_s = {TILE_W{1'b0}};
        end
        blocked_s = oob_s || ((tgt_tile_s == T_WALL) && !no_clip_s);
    end

    // Command FSM next-state and result code.
    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        evt_valid_d   = 1'b0;
        sweep_start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) state_d = ST_EXEC;
                else           state_d = ST_IDLE;
            end
            ST_EXEC: begin
                if (is_move_s && !blocked_s) begin
                    state_d       = ST_REVEAL;
                    sweep_start_s = 1'b1;
                    pos_x_d       = tx_s[XW-1:0];
                    pos_y_d       = ty_s[YW-1:0];
                    if (tgt_tile_s == T_EXIT) code_d = EVT_EXIT;
                    else                      code_d = EVT_MOVED;
                end else begin
                    state_d     = ST_DONE;
                    evt_valid_d = 1'b1;
                    if (is_move_s)       code_d = EVT_BLOCKED;
                    else if (is_cheat_s) code_d = EVT_TOGGLED;
                    else                 code_d = EVT_ILLEGAL;
                end
            end
            ST_REVEAL: begin
                if (sweep_last_s) begin
                    state_d     = ST_DONE;
                    evt_valid_d = !boot_q;
                end else begin
                    state_d = ST_REVEAL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts into the start-window reveal.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_REVEAL;
            code_q      <= EVT_MOVED;
            cmd_q       <= 8'h00;
            pos_x_q     <= START_X_P;
            pos_y_q     <= START_Y_P;
            cmd_ready_q <= 1'b0;
            evt_valid_q <= 1'b0;
            boot_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            evt_valid_q <= evt_valid_d;
            if ((state_q == ST_IDLE) && cmd_valid) cmd_q <= cmd;
            if (state_q == ST_DONE) boot_q <= 1'b0;
        end
    end

    nav_reveal_sweep #(
        .MAP_W  (MAP_W),
        .MAP_H  (MAP_H),
        .VIEW_R (VIEW_R),
        .AW     (AW),
        .XW     (XW),
        .YW     (YW)
    ) u_sweep (
        .clk         (clk),
        .reset       (reset),
        .start_i     (sweep_start_s),
        .cx_i        (pos_x_q),
        .cy_i        (pos_y_q),
        .cell_we_o   (cell_we_s),
        .cell_addr_o (cell_addr_s),
        .last_o      (sweep_last_s)
    );

    assign cmd_ready = cmd_ready_q;
    assign busy      = !cmd_ready_q;
    assign evt_valid = evt_valid_q;
    assign evt_code  = code_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign rd_tile   = rd_tile_q;
    assign rd_seen   = rd_seen_q;
    assign no_shroud = no_shroud_s;

endmodule

// File: tb/tb_dungeon_nav_engine.sv
// Scoreboard bench for dungeon_nav_engine: expected events are queued when a
// command is driven and compared when evt_valid fires; seen bits use a model.
module tb_dungeon_nav_engine;

    localparam int W = 20, H = 20, TW = 4, R = 2, SX = 10, SY = 2;
    localparam int N = W * H, AW = $clog2(N), XW = $clog2(W), YW = $clog2(H);
    localparam int SWEEP = (2*R+1) * (2*R+1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          map_we = 1'b0;
    logic [AW-1:0] map_waddr = '0;
    logic [TW-1:0] map_wdata = '0;
    logic          cmd_valid = 1'b0;
    logic [7:0]    cmd = 8'h00;
    logic          cmd_ready, busy, evt_valid, rd_seen, no_shroud;
    logic [2:0]    evt_code;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic [AW-1:0] rd_addr = '0;
    logic [TW-1:0] rd_tile;

    dungeon_nav_engine #(
        .MAP_W(W), .MAP_H(H), .TILE_W(TW), .VIEW_R(R), .START_X(SX), .START_Y(SY)
    ) dut (
        .clk(clk), .reset(reset), .map_we(map_we), .map_waddr(map_waddr),
        .map_wdata(map_wdata), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .busy(busy), .evt_valid(evt_valid),
        .evt_code(evt_code), .pos_x(pos_x), .pos_y(pos_y), .rd_addr(rd_addr),
        .rd_tile(rd_tile), .rd_seen(rd_seen), .no_shroud(no_shroud)
    );

    always #5 clk = ~clk;

    typedef struct {int code; int lat; int x; int y;} exp_t;
    exp_t sb_q[$];
    int   n_total = 0, n_bad = 0;
    int   m_map[N];
    bit   m_seen[N];
    int   m_x, m_y;
    bit   m_clip, m_shroud;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic m_reveal(input int cx, input int cy);
        for (int dy = -R; dy <= R; dy++)
            for (int dx = -R; dx <= R; dx++) begin
                int ad, x, y;
                x = cx + dx; y = cy + dy;
                ad = (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
                if (x >= 0 && x < W && y >= 0 && y < H && ad <= R) m_seen[y*W+x] = 1'b1;
            end
    endtask

    task automatic m_reset();
        m_x = SX; m_y = SY; m_clip = 1'b0; m_shroud = 1'b0;
        for (int a = 0; a < N; a++) m_seen[a] = 1'b0;
        m_reveal(SX, SY);
    endtask

    task automatic wr_tile(input int x, input int y, input int t);
        map_we = 1'b1; map_waddr = AW'(y*W+x); map_wdata = TW'(t);
        @(negedge clk);
        map_we = 1'b0;
        m_map[y*W+x] = t;
    endtask

    task automatic check_cell(input int x, input int y);
        rd_addr = AW'(y*W+x);
        @(negedge clk);
        check($sformatf("seen(%0d,%0d)", x, y), rd_seen, int'(m_shroud | m_seen[y*W+x]));
    endtask

    task automatic scan_seen(input string tag);
        rd_addr = '0;
        for (int a = 0; a < N; a++) begin
            @(negedge clk);
            check($sformatf("%s_seen[%0d]", tag, a), rd_seen, int'(m_shroud | m_seen[a]));
            if (a + 1 < N) rd_addr = AW'(a + 1);
        end
    endtask

    task automatic wait_boot(input string tag);
        int nb, ev;
        nb = 0; ev = 0;
        for (int k = 0; k < 100 && !cmd_ready; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (evt_valid) ev++;
        end
        check({tag, "_busy_cycles"}, nb, SWEEP);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_no_evt"}, ev, 0);
    endtask

    task automatic wait_evt();
        exp_t e;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!evt_valid && n < 200);
        e = sb_q.pop_front();
        check("evt_seen", evt_valid, 1);
        check("evt_latency", n, e.lat);
        check("evt_code", evt_code, e.code);
        check("pos_x", pos_x, e.x);
        check("pos_y", pos_y, e.y);
        @(negedge clk);
        check("evt_one_cycle", evt_valid, 0);
        check("ready_after_evt", cmd_ready, 1);
    endtask

    task automatic send(input int c);
        exp_t e;
        int   tx, ty;
        bit   mv, bad;
        check("ready_before_cmd", cmd_ready, 1);
        mv = 1'b1; bad = 1'b0; tx = m_x; ty = m_y;
        case (c)
            1: if (m_x + 1 >= W) bad = 1'b1; else tx = m_x + 1;
            2: if (m_x == 0)     bad = 1'b1; else tx = m_x - 1;
            3: if (m_y == 0)     bad = 1'b1; else ty = m_y - 1;
            4: if (m_y + 1 >= H) bad = 1'b1; else ty = m_y + 1;
            default: mv = 1'b0;
        endcase
        if (mv && !bad && m_map[ty*W+tx] == 5 && !m_clip) bad = 1'b1;
        if (mv && !bad) begin
            e.code = (m_map[ty*W+tx] == 3) ? 2 : 0;
            e.lat  = 2 + SWEEP;
            m_x = tx; m_y = ty;
            m_reveal(tx, ty);
        end else if (mv) begin
            e.code = 1; e.lat = 2;
`ifdef NAV_CHEATS_EN
        end else if (c == 16) begin
            e.code = 3; e.lat = 2; m_shroud = !m_shroud;
        end else if (c == 17) begin
            e.code = 3; e.lat = 2; m_clip = !m_clip;
`endif
        end else begin
            e.code = 4; e.lat = 2;
        end
        e.x = m_x; e.y = m_y;
        sb_q.push_back(e);
        cmd_valid = 1'b1; cmd = 8'(c);
        @(posedge clk);
        #1 cmd_valid = 1'b0; cmd = 8'h00;
        wait_evt();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        map_we = 1'b1;
        for (int a = 0; a < N; a++) begin
            map_waddr = AW'(a); map_wdata = TW'(4);
            m_map[a] = 4;
            @(negedge clk);
        end
        map_we = 1'b0;

        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_evt", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_pos_x", pos_x, SX);
        check("rst_pos_y", pos_y, SY);
        check("rst_shroud", no_shroud, 0);
        check("rst_tile", rd_tile, 0);
        check("rst_seen", rd_seen, 0);

        m_reset();
        reset = 1'b0;
        wait_boot("boot");
        for (int dy = -R; dy <= R; dy++)
            for (int dx = -R; dx <= R; dx++) check_cell(SX + dx, SY + dy);
        check_cell(10, 5);

        // Write latency on the render port with rd_addr held.
        rd_addr = AW'(2*W + 11);
        @(negedge clk);
        wr_tile(11, 2, 5);
        check("rd_tile_old", rd_tile, 4);
        @(negedge clk);
        check("rd_tile_new", rd_tile, 5);

        send(1);
`ifdef NAV_CHEATS_EN
        send(17);
        send(1);
        send(2);
        send(17);
        send(16);
        check("shroud_on", no_shroud, 1);
        check_cell(10, 15);
        send(16);
`else
        send(16);
        check("shroud_stuck", no_shroud, 0);
        send(17);
`endif
        send(8'h07);

        wr_tile(10, 3, 3);
        send(4);
        check_cell(10, 5);

        for (int k = 0; k < 3; k++) send(3);
        for (int k = 0; k < 10; k++) send(2);
        send(2);
        check("no_wrap_x", pos_x, 0);
        send(3);
        check("no_wrap_y", pos_y, 0);
        send(1);
        send(4);
        send(2);
        scan_seen("corner");

        // Abort a legal move mid-reveal with reset.
        begin
            int ev;
            ev = 0;
            cmd_valid = 1'b1; cmd = 8'h01;
            @(posedge clk);
            #1 cmd_valid = 1'b0; cmd = 8'h00;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (evt_valid) ev++;
            end
            reset = 1'b1;
            @(negedge clk);
            if (evt_valid) ev++;
            reset = 1'b0;
            check("abort_no_evt", ev, 0);
        end
        m_reset();
        check("abort_pos_x", pos_x, SX);
        check("abort_pos_y", pos_y, SY);
        wait_boot("abort");
        scan_seen("abort");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
